// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller: command encodings, arbiter
// state encoding and default bus widths.
package sdram_pkg;

  localparam int DQ_W_DEF   = 16;
  localparam int ADDR_W_DEF = 13;
  localparam int BA_W_DEF   = 2;

  // Commands are {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP        = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE     = 4'b0011;
  localparam logic [3:0] CMD_READ       = 4'b0101;
  localparam logic [3:0] CMD_WRITE      = 4'b0100;
  localparam logic [3:0] CMD_BURST_STOP = 4'b0110;
  localparam logic [3:0] CMD_PRECHARGE  = 4'b0010;
  localparam logic [3:0] CMD_AREF       = 4'b0001;
  localparam logic [3:0] CMD_MODE_REG   = 4'b0000;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_ARBIT,
    ST_AREF,
    ST_WRITE,
    ST_READ
  } arb_state_e;

endpackage

// File: rtl/sdram_arbit.sv
// Central SDRAM bus arbiter: grants refresh / write / read with fixed priority
// after initialisation and muxes the owning source's command bus onto the pins.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int DQ_W   = DQ_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BA_W   = BA_W_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [BA_W-1:0]   init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [BA_W-1:0]   aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_sdram_en,
  input  logic [DQ_W-1:0]   wr_sdram_data,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [BA_W-1:0]   rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DQ_W-1:0]   sdram_dq_out,
  output logic              sdram_dq_oe
);

  arb_state_e state_q, state_d;
  logic       aref_en_q, wr_en_q, rd_en_q;

  logic [3:0]        cmd_mux;
  logic [BA_W-1:0]   ba_mux;
  logic [ADDR_W-1:0] addr_mux;

  // Every grant passes back through ARBIT, which guarantees one NOP cycle
  // between consecutive owners.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT: begin
        if (init_end) state_d = ST_ARBIT;
      end
      ST_ARBIT: begin
        if (aref_req)     state_d = ST_AREF;
        else if (wr_req)  state_d = ST_WRITE;
        else if (rd_req)  state_d = ST_READ;
      end
      ST_AREF: begin
        if (aref_end) state_d = ST_ARBIT;
      end
      ST_WRITE: begin
        if (wr_end) state_d = ST_ARBIT;
      end
      ST_READ: begin
        if (rd_end) state_d = ST_ARBIT;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Grants are registered from the next state so they align with the state.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= ST_INIT;
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      aref_en_q <= (state_d == ST_AREF);
      wr_en_q   <= (state_d == ST_WRITE);
      rd_en_q   <= (state_d == ST_READ);
    end
  end

  always_comb begin
    cmd_mux  = CMD_NOP;
    ba_mux   = '1;
    addr_mux = '1;
    unique case (state_q)
      ST_INIT: begin
        cmd_mux  = init_cmd;
        ba_mux   = init_ba;
        addr_mux = init_addr;
      end
      ST_AREF: begin
        cmd_mux  = aref_cmd;
        ba_mux   = aref_ba;
        addr_mux = aref_addr;
      end
      ST_WRITE: begin
        cmd_mux  = wr_cmd;
        ba_mux   = wr_ba;
        addr_mux = wr_addr;
      end
      ST_READ: begin
        cmd_mux  = rd_cmd;
        ba_mux   = rd_ba;
        addr_mux = rd_addr;
      end
      default: begin
        cmd_mux  = CMD_NOP;
        ba_mux   = '1;
        addr_mux = '1;
      end
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_mux;
  assign sdram_ba     = ba_mux;
  assign sdram_addr   = addr_mux;
  assign sdram_cke    = 1'b1;

  assign sdram_dq_oe  = (state_q == ST_WRITE) && wr_sdram_en;
  assign sdram_dq_out = (state_q == ST_WRITE) ? wr_sdram_data : '0;

  assign aref_en = aref_en_q;
  assign wr_en   = wr_en_q;
  assign rd_en   = rd_en_q;

endmodule

// File: doc/sdram_arbit.md
# sdram_arbit

- Central arbiter of the SDRAM controller.
- After initialisation, grants the bus to one of three command sources at a time: auto-refresh, page-burst write, or page-burst read.
- Drives the selected source's command, bank and address onto the SDRAM pins, and drives write data and its output enable.
- Sits directly upstream of the read and write burst modules: produces their `rd_en`/`wr_en` and consumes their `rd_end`/`wr_end`.

## Interface
Parameters:
- `DQ_W`, 16, SDRAM data width
- `ADDR_W`, 13, SDRAM address width
- `BA_W`, 2, bank address width

Ports:
- `sys_clk` in 1: single clock; all logic on rising edge
- `sys_rst` in 1: asynchronous, active-high reset
- `init_end` in 1: initialisation done
- `init_cmd`, `init_ba`, `init_addr` in 4/`BA_W`/`ADDR_W`: init module command bus
- `aref_req` in 1: refresh request
- `aref_end` in 1: refresh sequence done
- `aref_cmd`, `aref_ba`, `aref_addr` in 4/`BA_W`/`ADDR_W`: refresh module command bus
- `wr_req` in 1: write request
- `wr_end` in 1: write burst done
- `wr_cmd`, `wr_ba`, `wr_addr` in 4/`BA_W`/`ADDR_W`: write module command bus
- `wr_sdram_en` in 1: write data valid
- `wr_sdram_data` in `DQ_W`: write data
- `rd_req` in 1: read request
- `rd_end` in 1: read burst done
- `rd_cmd`, `rd_ba`, `rd_addr` in 4/`BA_W`/`ADDR_W`: read module command bus
- `aref_en`, `wr_en`, `rd_en` out 1 each: grant to the corresponding module
- `sdram_cke` out 1: clock enable
- `sdram_cs_n`, `sdram_ras_n`, `sdram_cas_n`, `sdram_we_n` out 1 each: command pins
- `sdram_ba` out `BA_W`, `sdram_addr` out `ADDR_W`: bank and address pins
- `sdram_dq_out` out `DQ_W`: write data to DQ pad
- `sdram_dq_oe` out 1: DQ output enable

## Operation
- Command encoding: {cs_n, ras_n, cas_n, we_n}. NOP = 4'b0111.
- States:
  - INIT: wait for `init_end`; then go to ARBIT. `init_end` is sampled once; a later deassertion is ignored.
  - ARBIT: fixed priority `aref_req` > `wr_req` > `rd_req`. Go to AREF/WRITE/READ accordingly; stay in ARBIT if no request is present.
  - AREF / WRITE / READ: hold until the matching `*_end` is sampled high, then return to ARBIT.
- Grants:
  - `aref_en`, `wr_en`, `rd_en` are registered and high exactly while in AREF, WRITE, READ respectively.
  - Never more than one grant is high at once.
- Command mux (combinational from the state register):
  - INIT → `init_*`
  - AREF → `aref_*`
  - WRITE → `wr_*`
  - READ → `rd_*`
  - ARBIT → cmd NOP, ba all-ones, addr all-ones
- Write data path:
  - `sdram_dq_oe` = `wr_sdram_en` while in WRITE, else 0.
  - `sdram_dq_out` = `wr_sdram_data` while in WRITE, else 0.
- `sdram_cke` is 1 at all times, including during reset.
- Requests arriving outside ARBIT are not latched. Requesters hold `*_req` until they see their grant.
- A `*_end` from a module that holds no grant is ignored.

## Timing
- Reset values:
  - state INIT; all grants 0; `sdram_dq_oe` 0; `sdram_dq_out` 0.
  - Command pins follow `init_*`; the init module drives NOP while in reset.
- Latency:
  - Request sampled in ARBIT at edge N → grant high and source's command on the pins from cycle N+1.
  - `*_end` sampled at edge M → grant low and NOP on the pins from M+1.
- Minimum one ARBIT (NOP) cycle between consecutive grants, even with back-to-back requests.
- `*_end` and a new request in the same cycle: return to ARBIT first; the new request is granted one cycle later.
- Simultaneous requests: the higher priority wins; losers remain pending and are re-evaluated on every ARBIT cycle.
- A starved read is permitted by the fixed priority. The refresh interval guarantees ARBIT windows.
- Reset asserted mid-burst: immediate return to INIT; grants drop asynchronously; `init_end` must be re-seen before any new grant.

## Structure
- Shared package `sdram_pkg`:
  - command localparams: NOP, ACTIVE, READ, WRITE, BURST_STOP, PRECHARGE, AREF, MODE_REG
  - state encoding: INIT, ARBIT, AREF, WRITE, READ
  - default widths
- No sub-module. The arbiter FSM and the command mux live in one file of roughly 150–200 lines.

## Test plan
- Reset, then `init_end` pulse: state INIT → ARBIT; pins show NOP (4'b0111, ba 2'b11, addr 13'h1FFF); all grants 0.
- `rd_req` alone in ARBIT at cycle N: `rd_en`=1 from N+1; `rd_cmd`=4'b0011 with `rd_addr`=13'h0040 appears on the pins; `rd_end` at M → `rd_en`=0 and NOP at M+1.
- `aref_req`, `wr_req` and `rd_req` all high in the same cycle: `aref_en` granted first. After `aref_end`, one NOP cycle, then `wr_en`; after `wr_end`, one NOP cycle, then `rd_en`.
- WRITE with `wr_sdram_en`=1 and data 16'hA5A5: `sdram_dq_oe`=1 and `sdram_dq_out`=16'hA5A5 the same cycle. Outside WRITE, `wr_sdram_en`=1 yields `sdram_dq_oe`=0.
- `rd_end` pulsed while WRITE is active: ignored, `wr_en` stays 1. `wr_req` raised during READ: not granted until the ARBIT cycle after `rd_end`.
- `sys_rst` asserted mid-READ: `rd_en`=0 immediately; after reset release, no grant occurs until `init_end`=1.
